// File: rtl/dmg_bus_responder.sv
// rtl/dmg_bus_responder.sv - high-RAM window responder on the core address/data bus
module dmg_bus_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF80,
  parameter int          DEPTH       = 127,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MREQ,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] A,
  input  logic [7:0]  DL_in,
  output logic [7:0]  DL_out,
  output logic        DL_oe,
  output logic        READY,
  output logic        BUSY,
  output logic        ERR
);

  localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] DEPTH16   = 16'(DEPTH);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx_q;
  logic [7:0]    data_q;
  logic          rd_q;
  logic [2:0]    wait_cnt;
  logic [7:0]    ram [0:DEPTH-1];

  logic [15:0]   a_off;
  logic          a_hit;

  // 16-bit wrap of the subtract is harmless: the >= guard rejects low addresses
  assign a_off = A - BASE_ADDR;
  assign a_hit = (A >= BASE_ADDR) && (a_off < DEPTH16);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      idx_q    <= '0;
      data_q   <= 8'h00;
      rd_q     <= 1'b0;
      wait_cnt <= 3'd0;
      DL_out   <= 8'h00;
      DL_oe    <= 1'b0;
      READY    <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      READY <= 1'b0;
      ERR   <= 1'b0;
      DL_oe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (MREQ) begin
            if (RD && WR) begin
              ERR <= 1'b1;
            end else if ((RD || WR) && a_hit) begin
              idx_q  <= a_off[IW-1:0];
              data_q <= DL_in;
              rd_q   <= RD;
              BUSY   <= 1'b1;
              if (WAIT_STATES > 0) begin
                state    <= S_WAIT;
                wait_cnt <= WAIT_LOAD;
              end else begin
                state <= S_DONE;
                READY <= 1'b1;
                DL_oe <= RD;
                if (RD) DL_out <= ram[a_off[IW-1:0]];
              end
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state <= S_DONE;
            READY <= 1'b1;
            DL_oe <= rd_q;
            if (rd_q) DL_out <= ram[idx_q];
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is deliberately outside the reset domain; a reset clears state before DONE can exit
  always_ff @(posedge CLK) begin
    if (state == S_DONE && !rd_q) ram[idx_q] <= data_q;
  end

endmodule

// File: tb/tb_dmg_bus_responder.sv
// tb/tb_dmg_bus_responder.sv - scoreboard bench for dmg_bus_responder at 0, 2 and 3 wait states
module tb_dmg_bus_responder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [7:0]  DL_in = 8'h00;
  logic [2:0]  mreq = 3'b000;
  logic [7:0]  dl_out [3];
  logic [2:0]  dl_oe, ready, busy, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int         inst;
    bit         rd;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  always #5 CLK = ~CLK;

  dmg_bus_responder #(.WAIT_STATES(0)) u0 (
    .CLK(CLK), .RESET(RESET), .MREQ(mreq[0]), .RD(RD), .WR(WR), .A(A), .DL_in(DL_in),
    .DL_out(dl_out[0]), .DL_oe(dl_oe[0]), .READY(ready[0]), .BUSY(busy[0]), .ERR(err[0]));
  dmg_bus_responder #(.WAIT_STATES(2)) u2 (
    .CLK(CLK), .RESET(RESET), .MREQ(mreq[1]), .RD(RD), .WR(WR), .A(A), .DL_in(DL_in),
    .DL_out(dl_out[1]), .DL_oe(dl_oe[1]), .READY(ready[1]), .BUSY(busy[1]), .ERR(err[1]));
  dmg_bus_responder #(.WAIT_STATES(3)) u3 (
    .CLK(CLK), .RESET(RESET), .MREQ(mreq[2]), .RD(RD), .WR(WR), .A(A), .DL_in(DL_in),
    .DL_out(dl_out[2]), .DL_oe(dl_oe[2]), .READY(ready[2]), .BUSY(busy[2]), .ERR(err[2]));

  // every READY pops one expected completion; a READY with nothing queued is spurious
  always @(negedge CLK) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (ready[i] === 1'b1) begin
        total_cnt++;
        if (sbq.size() == 0) begin
          $display("FAIL spurious_ready inst=%0d got READY=1 expected no completion", i);
        end else begin
          e = sbq.pop_front();
          if (e.inst != i || dl_oe[i] !== e.rd || (e.rd && dl_out[i] !== e.data))
            $display("FAIL scoreboard inst=%0d got oe=%0b data=%h expected inst=%0d oe=%0b data=%h",
                     i, dl_oe[i], dl_out[i], e.inst, e.rd, e.data);
          else
            pass_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(int i, bit rd, logic [7:0] d);
    exp_t e;
    e.inst = i;
    e.rd   = rd;
    e.data = d;
    sbq.push_back(e);
  endtask

  // one-cycle MREQ, then scramble the bus to show late changes have no effect
  task automatic issue(int i, bit rd, bit wr, logic [15:0] addr, logic [7:0] d);
    A = addr;
    DL_in = d;
    RD = rd;
    WR = wr;
    mreq[i] = 1'b1;
    step();
    mreq[i] = 1'b0;
    A = 16'($urandom);
    DL_in = 8'($urandom);
    RD = 1'($urandom);
    WR = 1'($urandom);
  endtask

  task automatic wait_ready(int i, output int lat);
    lat = 1;
    while (ready[i] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    if (ready[i] !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    int lat;
    step();
    RESET = 1'b1;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({dl_out[i], dl_oe[i], ready[i], busy[i], err[i]} !== 12'h000)
        $display("FAIL reset_outputs inst=%0d got %h expected 000", i,
                 {dl_out[i], dl_oe[i], ready[i], busy[i], err[i]});
      else pass_cnt++;
    end
    RESET = 1'b0;
    step();
    push(1, 1'b0, 8'h00);
    issue(1, 1'b0, 1'b1, 16'hFF88, 8'h11);
    wait_ready(1, lat);
    total_cnt++;
    if (lat !== 3) $display("FAIL ws2_latency got %0d expected 3", lat); else pass_cnt++;
    step();
    issue(1, 1'b0, 1'b1, 16'hFF88, 8'hEE);
    total_cnt++;
    if (busy[1] !== 1'b1) $display("FAIL ws2_busy_in_wait got %b expected 1", busy[1]); else pass_cnt++;
    RESET = 1'b1;
    #1;
    total_cnt++;
    if ({dl_out[1], dl_oe[1], ready[1], busy[1], err[1]} !== 12'h000)
      $display("FAIL reset_mid_wait got %h expected 000", {dl_out[1], dl_oe[1], ready[1], busy[1], err[1]});
    else pass_cnt++;
    step();
    RESET = 1'b0;
    step();
    push(1, 1'b1, 8'h11);
    issue(1, 1'b1, 1'b0, 16'hFF88, 8'h00);
    wait_ready(1, lat);
    total_cnt++;
    if (lat !== 3) $display("FAIL ws2_read_latency got %0d expected 3", lat); else pass_cnt++;
    step();
  endtask

  task automatic test_write_read();
    int lat;
    push(0, 1'b0, 8'h00);
    issue(0, 1'b0, 1'b1, 16'hFF80, 8'h5A);
    wait_ready(0, lat);
    total_cnt++;
    if (lat !== 1) $display("FAIL wr_latency got %0d expected 1", lat); else pass_cnt++;
    step();
    push(0, 1'b1, 8'h5A);
    issue(0, 1'b1, 1'b0, 16'hFF80, 8'h00);
    wait_ready(0, lat);
    total_cnt++;
    if (lat !== 1) $display("FAIL rd_latency got %0d expected 1", lat); else pass_cnt++;
    step();
    total_cnt++;
    if ({dl_oe[0], ready[0], busy[0], dl_out[0]} !== {3'b000, 8'h5A})
      $display("FAIL rd_after_done got oe=%b rdy=%b busy=%b data=%h expected 0 0 0 5a",
               dl_oe[0], ready[0], busy[0], dl_out[0]);
    else pass_cnt++;
  endtask

  task automatic test_boundaries();
    int lat;
    int bad;
    logic [15:0] miss [2];
    push(0, 1'b0, 8'h00);
    issue(0, 1'b0, 1'b1, 16'hFFFE, 8'hC3);
    wait_ready(0, lat);
    step();
    push(0, 1'b1, 8'hC3);
    issue(0, 1'b1, 1'b0, 16'hFFFE, 8'h00);
    wait_ready(0, lat);
    total_cnt++;
    if (lat !== 1) $display("FAIL top_read_latency got %0d expected 1", lat); else pass_cnt++;
    step();
    miss[0] = 16'hFFFF;
    miss[1] = 16'hFF7F;
    for (int m = 0; m < 2; m++) begin
      issue(0, 1'b1, 1'b0, miss[m], 8'h00);
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if ((ready[0] | dl_oe[0] | busy[0] | err[0]) !== 1'b0) bad++;
        step();
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL miss_%h got %0d active cycles expected 0", miss[m], bad);
      else pass_cnt++;
    end
  endtask

  task automatic test_wait_states();
    int lat;
    int bad;
    push(2, 1'b0, 8'h00);
    issue(2, 1'b0, 1'b1, 16'hFF90, 8'h77);
    wait_ready(2, lat);
    step();
    push(2, 1'b0, 8'h00);
    issue(2, 1'b0, 1'b1, 16'hFF91, 8'h12);
    wait_ready(2, lat);
    step();
    push(2, 1'b1, 8'h77);
    issue(2, 1'b1, 1'b0, 16'hFF90, 8'h00);
    A = 16'hFF91;
    DL_in = 8'h99;
    RD = 1'b0;
    WR = 1'b1;
    mreq[2] = 1'b1;
    lat = 1;
    bad = 0;
    while (ready[2] !== 1'b1 && lat < 20) begin
      if (busy[2] !== 1'b1) bad++;
      step();
      lat++;
    end
    mreq[2] = 1'b0;
    total_cnt++;
    if (lat !== 4) $display("FAIL ws3_latency got %0d expected 4", lat); else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL ws3_busy got %0d idle wait cycles expected 0", bad); else pass_cnt++;
    step();
    push(2, 1'b1, 8'h12);
    issue(2, 1'b1, 1'b0, 16'hFF91, 8'h00);
    wait_ready(2, lat);
    step();
  endtask

  task automatic test_error();
    int lat;
    push(0, 1'b0, 8'h00);
    issue(0, 1'b0, 1'b1, 16'hFF85, 8'h3C);
    wait_ready(0, lat);
    step();
    issue(0, 1'b1, 1'b1, 16'hFF85, 8'hFF);
    total_cnt++;
    if ({err[0], ready[0], busy[0]} !== 3'b100)
      $display("FAIL err_pulse got err=%b rdy=%b busy=%b expected 1 0 0", err[0], ready[0], busy[0]);
    else pass_cnt++;
    step();
    total_cnt++;
    if (err[0] !== 1'b0) $display("FAIL err_width got %b expected 0", err[0]); else pass_cnt++;
    push(0, 1'b1, 8'h3C);
    issue(0, 1'b1, 1'b0, 16'hFF85, 8'h00);
    wait_ready(0, lat);
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad = 0;
    logic [15:0] addr;
    for (int a = 16'hFF80; a <= 16'hFFFE; a++) begin
      addr = 16'(a);
      push(0, 1'b0, 8'h00);
      issue(0, 1'b0, 1'b1, addr, addr[7:0] ^ 8'hA5);
      wait_ready(0, lat);
      if (lat != 1) bad++;
      step();
      push(0, 1'b1, addr[7:0] ^ 8'hA5);
      issue(0, 1'b1, 1'b0, addr, 8'h00);
      wait_ready(0, lat);
      if (lat != 1) bad++;
      step();
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL b2b_latency got %0d late accesses expected 0", bad); else pass_cnt++;
    step();
    total_cnt++;
    if (sbq.size() !== 0) $display("FAIL lost_requests got %0d pending expected 0", sbq.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_boundaries();
    test_wait_states();
    test_error();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
